// File: rtl/write_back_buffer.sv
// Register write-back FIFO: queues datapath writes, retires one per cycle to the
// register file port, and forwards the youngest pending value to operand reads.
module write_back_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        InValid,
  input  logic [4:0]  InAddr,
  input  logic [31:0] InData,
  output logic        InReady,
  input  logic        Stall,
  output logic [4:0]  Awr,
  output logic [31:0] Din,
  output logic        WrEn,
  input  logic [4:0]  Adr1,
  input  logic [4:0]  Adr2,
  output logic        Hit1,
  output logic        Hit2,
  output logic [31:0] FwdData1,
  output logic [31:0] FwdData2,
  output logic [CW-1:0] Count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop in the same cycle never frees space for that cycle's push.
  assign InReady = !w_full;
  // R0 writes complete the handshake but are never stored.
  assign w_push  = InValid && !w_full && (InAddr != 5'd0) && !Rst;
  assign w_pop   = !w_empty && !Stall;

  assign WrEn  = w_pop;
  assign Awr   = w_empty ? 5'd0  : r_addr[r_head];
  assign Din   = w_empty ? 32'd0 : r_data[r_head];
  assign Count = r_count;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_addr[r_tail] <= InAddr;
      r_data[r_tail] <= InData;
    end
  end

  // Per-age match vectors: age 0 is the head (oldest), higher ages are younger.
  logic [AW-1:0]    w_slot [DEPTH];
  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_m1;
  logic [DEPTH-1:0] w_m2;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign w_slot[gi] = r_head + AW'(gi);
      assign w_vld[gi]  = (CW'(gi) < r_count);
      assign w_m1[gi]   = w_vld[gi] && (Adr1 != 5'd0) && (r_addr[w_slot[gi]] == Adr1);
      assign w_m2[gi]   = w_vld[gi] && (Adr2 != 5'd0) && (r_addr[w_slot[gi]] == Adr2);
    end
  endgenerate

  logic        w_hit1;
  logic        w_hit2;
  logic [31:0] w_fwd1;
  logic [31:0] w_fwd2;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_fwd1 = 32'd0;
    w_fwd2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_m1[i]) begin
        w_hit1 = 1'b1;
        w_fwd1 = r_data[w_slot[i]];
      end
      if (w_m2[i]) begin
        w_hit2 = 1'b1;
        w_fwd2 = r_data[w_slot[i]];
      end
    end
  end

  assign Hit1     = w_hit1;
  assign Hit2     = w_hit2;
  assign FwdData1 = w_fwd1;
  assign FwdData2 = w_fwd2;

endmodule

// File: tb/tb_write_back_buffer.sv
// Directed checks of the write-back buffer plus a short randomized run against a
// reference queue; a small register-file model captures the write port.
module tb_write_back_buffer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        InValid;
  logic [4:0]  InAddr;
  logic [31:0] InData;
  logic        InReady;
  logic        Stall;
  logic [4:0]  Awr;
  logic [31:0] Din;
  logic        WrEn;
  logic [4:0]  Adr1;
  logic [4:0]  Adr2;
  logic        Hit1;
  logic        Hit2;
  logic [31:0] FwdData1;
  logic [31:0] FwdData2;
  logic [2:0]  Count;

  write_back_buffer #(.DEPTH(4), .CW(3)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InAddr(InAddr), .InData(InData),
    .InReady(InReady), .Stall(Stall), .Awr(Awr), .Din(Din), .WrEn(WrEn),
    .Adr1(Adr1), .Adr2(Adr2), .Hit1(Hit1), .Hit2(Hit2),
    .FwdData1(FwdData1), .FwdData2(FwdData2), .Count(Count)
  );

  always #5 Clk = ~Clk;

  logic [31:0] rf [32];
  int          wr_cnt = 0;

  always @(posedge Clk) begin
    if (WrEn) begin
      rf[Awr] <= Din;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];

  initial begin
    int          saved;
    logic        e_rdy;
    logic        e_wr;
    logic        e_hit;
    logic [31:0] e_fwd;
    logic [2:0]  e_cnt;

    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    Rst = 1'b1; InValid = 1'b0; InAddr = 5'd0; InData = 32'd0;
    Stall = 1'b0; Adr1 = 5'd0; Adr2 = 5'd0;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_inready", InReady, 1);
    chk("rst_wren", WrEn, 0);
    chk("rst_awr", Awr, 0);
    chk("rst_din", Din, 0);
    chk("rst_hit1", Hit1, 0);
    chk("rst_hit2", Hit2, 0);
    chk("rst_fwd1", FwdData1, 0);
    chk("rst_fwd2", FwdData2, 0);
    chk("rst_count", Count, 0);

    // Single write
    cyc(); Rst = 1'b0; InValid = 1'b1; InAddr = 5'd5; InData = 32'hDEADBEEF; Adr1 = 5'd5; #1;
    chk("single_rdy", InReady, 1);
    chk("single_nofwd_same_cycle", Hit1, 0);
    cyc(); InValid = 1'b0; #1;
    chk("single_wren", WrEn, 1);
    chk("single_awr", Awr, 5);
    chk("single_din", Din, 32'hDEADBEEF);
    chk("single_hit1", Hit1, 1);
    chk("single_fwd1", FwdData1, 32'hDEADBEEF);
    chk("single_count1", Count, 1);
    cyc(); #1;
    chk("single_count0", Count, 0);
    chk("single_wren0", WrEn, 0);
    chk("single_rf5", rf[5], 32'hDEADBEEF);
    chk("single_hit1_gone", Hit1, 0);

    // Fill under stall
    Stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc(); InValid = 1'b1; InAddr = 5'(i); InData = 32'(i * 16); #1;
      chk($sformatf("fill_rdy%0d", i), InReady, (i <= 4) ? 1 : 0);
      chk($sformatf("fill_nowr%0d", i), WrEn, 0);
    end
    chk("fill_count", Count, 4);
    cyc(); InValid = 1'b0; Stall = 1'b0; #1;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin cyc(); #1; end
      chk($sformatf("fill_wr%0d", k), WrEn, 1);
      chk($sformatf("fill_awr%0d", k), Awr, 32'(k));
      chk($sformatf("fill_din%0d", k), Din, 32'(k * 16));
    end
    cyc(); #1;
    chk("fill_empty", Count, 0);
    chk("fill_rf4", rf[4], 32'h40);
    chk("fill_rf5_untouched", rf[5], 32'hDEADBEEF);

    // Youngest-wins forwarding
    Stall = 1'b1; Adr2 = 5'd7;
    cyc(); InValid = 1'b1; InAddr = 5'd7; InData = 32'hA; #1;
    cyc(); InData = 32'hB; #1;
    chk("yw_fwd_after_one", FwdData2, 32'hA);
    cyc(); InValid = 1'b0; #1;
    chk("yw_hit2", Hit2, 1);
    chk("yw_fwd2", FwdData2, 32'hB);
    chk("yw_count", Count, 2);
    cyc(); Stall = 1'b0; #1;
    chk("yw_wr1_awr", Awr, 7);
    chk("yw_wr1_din", Din, 32'hA);
    chk("yw_wr1_fwd", FwdData2, 32'hB);
    cyc(); #1;
    chk("yw_wr2_din", Din, 32'hB);
    chk("yw_wr2_en", WrEn, 1);
    cyc(); #1;
    chk("yw_rf7", rf[7], 32'hB);
    chk("yw_hit2_gone", Hit2, 0);

    // R0 discard
    saved = wr_cnt;
    cyc(); InValid = 1'b1; InAddr = 5'd0; InData = 32'hFFFFFFFF; Adr1 = 5'd0; #1;
    chk("r0_rdy", InReady, 1);
    cyc(); InValid = 1'b0; #1;
    chk("r0_count", Count, 0);
    chk("r0_wren", WrEn, 0);
    chk("r0_hit1", Hit1, 0);
    cyc(); #1;
    chk("r0_nowrite", 32'(wr_cnt), 32'(saved));

    // Full with simultaneous pop
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); InValid = 1'b1; InAddr = 5'(8 + i); InData = 32'h100 + 32'(i); #1;
    end
    cyc(); Stall = 1'b0; InAddr = 5'd12; InData = 32'hC; #1;
    chk("full_rdy0", InReady, 0);
    chk("full_wr", WrEn, 1);
    chk("full_awr8", Awr, 8);
    cyc(); #1;
    chk("full_count3", Count, 3);
    chk("full_rdy1", InReady, 1);
    chk("full_awr9", Awr, 9);
    cyc(); InValid = 1'b0; #1;
    chk("full_count3b", Count, 3);
    chk("full_awr10", Awr, 10);
    cyc(); #1;
    chk("full_awr11", Awr, 11);
    cyc(); #1;
    chk("full_awr12", Awr, 12);
    chk("full_din12", Din, 32'hC);
    cyc(); #1;
    chk("full_drained", Count, 0);

    // Random traffic against a reference queue
    q.delete();
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (c < 12) begin
        InValid = ($urandom_range(0, 3) != 0);
        Stall   = ($urandom_range(0, 3) == 0);
      end else begin
        InValid = 1'b0;
        Stall   = 1'b0;
      end
      InAddr = 5'($urandom_range(0, 7));
      InData = $urandom;
      Adr1   = 5'($urandom_range(0, 7));
      Adr2   = 5'($urandom_range(0, 7));
      #1;
      e_rdy = (q.size() != 4);
      e_wr  = (q.size() != 0) && !Stall;
      e_cnt = 3'(q.size());
      chk($sformatf("rnd%0d_rdy", c), InReady, e_rdy);
      chk($sformatf("rnd%0d_wr", c), WrEn, e_wr);
      chk($sformatf("rnd%0d_cnt", c), Count, e_cnt);
      chk($sformatf("rnd%0d_awr", c), Awr, (q.size() != 0) ? q[0].a : 5'd0);
      chk($sformatf("rnd%0d_din", c), Din, (q.size() != 0) ? q[0].d : 32'd0);
      e_hit = 1'b0; e_fwd = 32'd0;
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (!e_hit && Adr1 != 5'd0 && q[j].a == Adr1) begin e_hit = 1'b1; e_fwd = q[j].d; end
      end
      chk($sformatf("rnd%0d_hit1", c), Hit1, e_hit);
      chk($sformatf("rnd%0d_fwd1", c), FwdData1, e_fwd);
      e_hit = 1'b0; e_fwd = 32'd0;
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (!e_hit && Adr2 != 5'd0 && q[j].a == Adr2) begin e_hit = 1'b1; e_fwd = q[j].d; end
      end
      chk($sformatf("rnd%0d_hit2", c), Hit2, e_hit);
      chk($sformatf("rnd%0d_fwd2", c), FwdData2, e_fwd);
      if (e_wr) void'(q.pop_front());
      if (InValid && e_rdy && InAddr != 5'd0) q.push_back({InAddr, InData});
    end
    chk("rnd_empty", Count, 0);

    // Reset mid-operation
    Stall = 1'b1; Adr1 = 5'd21; Adr2 = 5'd3;
    for (int i = 0; i < 3; i++) begin
      cyc(); InValid = 1'b1; InAddr = 5'(20 + i); InData = 32'h500 + 32'(i); #1;
    end
    cyc(); InValid = 1'b1; InAddr = 5'd3; InData = 32'h33; #1;
    chk("mid_count3", Count, 3);
    chk("mid_hit1_pre", Hit1, 1);
    Rst = 1'b1; #1;
    saved = wr_cnt;
    cyc(); Rst = 1'b0; InValid = 1'b0; Stall = 1'b0; #1;
    chk("mid_count0", Count, 0);
    chk("mid_wren", WrEn, 0);
    chk("mid_hit1", Hit1, 0);
    chk("mid_hit2", Hit2, 0);
    chk("mid_rdy", InReady, 1);
    for (int i = 0; i < 4; i++) cyc();
    #1;
    chk("mid_no_stale_write", 32'(wr_cnt), 32'(saved));
    chk("mid_rf20_clean", rf[20], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
